// File: rtl/exponent_unit.sv
// exponent_unit: two-stage valid/ready exponent datapath for FP mul/div/sqrt; define EXPONENT_UNIT_SATURATE_EN to clamp e3 on overflow/underflow
module exponent_unit #(
    parameter int WIDTH     = 8,
    parameter int DEC_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     e1,
    input  logic [WIDTH-1:0]     e2,
    input  logic [DEC_WIDTH-1:0] decrement,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     e3,
    output logic                 shift,
    output logic                 overflow,
    output logic                 underflow
);
    localparam int W2 = WIDTH + 2;
    localparam int BIAS = 2 ** (WIDTH - 1) - 1;
    localparam logic signed [W2-1:0] BIAS_S = W2'(BIAS);
    localparam logic signed [W2-1:0] MAX_S = W2'(2 ** WIDTH - 1);

    logic                  s1_valid;
    logic                  s1_shift;
    logic signed [W2-1:0]  s1_e;
    logic [DEC_WIDTH-1:0]  s1_dec;
    logic                  s2_ready;
    logic signed [W2-1:0]  x1, x2, u, u_odd, e_n, dx, r;
    logic                  sh_n, of_n, uf_n;
    logic [WIDTH-1:0]      e3_n;

    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;

    // stage 1 arithmetic: operands widened by two bits so no intermediate wraps
    always_comb begin
        x1    = W2'(e1);
        x2    = W2'(e2);
        u     = x1 - BIAS_S;
        u_odd = W2'(u[0]);
        sh_n  = (op == 2'b10) && u[0];
        e_n   = op == 2'b00 ? x1 + x2 - BIAS_S :
                op == 2'b01 ? x1 - x2 + BIAS_S :
                op == 2'b10 ? ((u - u_odd) >>> 1) + BIAS_S : x1;
    end

    // stage 2 arithmetic: apply normalisation decrement and classify range
    always_comb begin
        dx   = W2'(s1_dec);
        r    = s1_e - dx;
        of_n = r >= MAX_S;
        uf_n = r[W2-1] || (r == '0);
`ifdef EXPONENT_UNIT_SATURATE_EN
        e3_n = of_n ? '1 : uf_n ? '0 : r[WIDTH-1:0];
`else
        e3_n = r[WIDTH-1:0];
`endif
    end

    // stage 1 register: loads whenever it is empty or draining into stage 2
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_e     <= '0;
            s1_shift <= 1'b0;
            s1_dec   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_e     <= e_n;
                s1_shift <= sh_n;
                s1_dec   <= decrement;
            end
        end
    end

    // stage 2 register: output data held while downstream stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            e3        <= '0;
            shift     <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                e3        <= e3_n;
                shift     <= s1_shift;
                overflow  <= of_n;
                underflow <= uf_n;
            end
        end
    end
endmodule
